// File: rtl/trng_pkg.sv
// Shared state encoding and default parameters for the ring-oscillator TRNG sequencer.
package trng_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        WARMUP  = 3'd1,
        COLLECT = 3'd2,
        VALID   = 3'd3,
        FAULT   = 3'd4
    } trng_state_e;

    localparam int TRNG_WARMUP_CYCLES = 64;
    localparam int TRNG_WORD_W        = 8;
    localparam int TRNG_REP_LIMIT     = 16;

endpackage

// File: rtl/trng_rep_test.sv
// Repetition-count health test: tracks the run of identical accepted bits.
// hit is combinational in the sampling cycle; no backpressure, sampling is gated by sample_en.
module trng_rep_test
    import trng_pkg::*;
#(
    parameter int REP_LIMIT = TRNG_REP_LIMIT
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic sample_en,
    input  logic bit_in,
    output logic hit
);

    localparam int RCW = $clog2(REP_LIMIT + 1);
    localparam logic [RCW-1:0] RUN_MAX = RCW'(REP_LIMIT);

    logic           prev_q, prev_d;
    logic [RCW-1:0] run_q, run_d;

    always_comb begin
        prev_d = prev_q;
        run_d  = run_q;
        if (clear) begin
            prev_d = 1'b0;
            run_d  = '0;
        end else if (sample_en) begin
            prev_d = bit_in;
            // A zero run means no bit has been accepted yet this session.
            if (run_q == '0 || bit_in != prev_q) begin
                run_d = RCW'(1);
            end else if (run_q != RUN_MAX) begin
                run_d = run_q + RCW'(1);
            end
        end
    end

    assign hit = sample_en && !clear && (run_d == RUN_MAX);

    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            prev_q <= 1'b0;
            run_q  <= '0;
        end else begin
            prev_q <= prev_d;
            run_q  <= run_d;
        end
    end

endmodule

// File: rtl/trng_sequencer.sv
// Ring enable, warm-up discard, word assembly and health-fault control for the TRNG.
// First word WARMUP_CYCLES+WORD_W+1 cycles after req; word held on word_valid until word_ack.
module trng_sequencer
    import trng_pkg::*;
#(
    parameter int WARMUP_CYCLES = TRNG_WARMUP_CYCLES,
    parameter int WORD_W        = TRNG_WORD_W,
    parameter int REP_LIMIT     = TRNG_REP_LIMIT
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req,
    input  logic              bit_in,
    output logic              ring_en,
    output logic [WORD_W-1:0] word_out,
    output logic              word_valid,
    input  logic              word_ack,
    output logic              fault,
    input  logic              clr_fault,
    output logic              busy
);

    localparam int WCW = $clog2(WARMUP_CYCLES + 1);
    localparam int BCW = $clog2(WORD_W + 1);
    localparam logic [WCW-1:0] WARM_LOAD = WCW'(WARMUP_CYCLES - 1);
    localparam logic [BCW-1:0] BIT_LAST  = BCW'(WORD_W - 1);

    trng_state_e       state_q;
    logic [WCW-1:0]    warm_q;
    logic [BCW-1:0]    bcnt_q;
    logic [WORD_W-1:0] shift_q;
    logic [WORD_W-1:0] word_q;
    logic              vld_q, ring_q, fault_q, busy_q;

    logic [WORD_W-1:0] shift_nxt;
    logic              sample_en, rep_clear, rep_hit;

    assign shift_nxt = {shift_q[WORD_W-2:0], bit_in};
    // A bit is only accepted while the session is still requested.
    assign sample_en = (state_q == COLLECT) && req;
    assign rep_clear = (state_q == IDLE) || (state_q == WARMUP);

    trng_rep_test #(
        .REP_LIMIT (REP_LIMIT)
    ) u_rep_test (
        .clk       (clk),
        .rst_n     (rst_n),
        .clear     (rep_clear),
        .sample_en (sample_en),
        .bit_in    (bit_in),
        .hit       (rep_hit)
    );

    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            state_q <= IDLE;
            warm_q  <= '0;
            bcnt_q  <= '0;
            shift_q <= '0;
            word_q  <= '0;
            vld_q   <= 1'b0;
            ring_q  <= 1'b0;
            fault_q <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (req) begin
                        state_q <= WARMUP;
                        warm_q  <= WARM_LOAD;
                        ring_q  <= 1'b1;
                        busy_q  <= 1'b1;
                    end
                end
                WARMUP: begin
                    if (!req) begin
                        state_q <= IDLE;
                        ring_q  <= 1'b0;
                        busy_q  <= 1'b0;
                    end else if (warm_q == '0) begin
                        state_q <= COLLECT;
                        bcnt_q  <= '0;
                    end else begin
                        warm_q <= warm_q - WCW'(1);
                    end
                end
                COLLECT: begin
                    if (!req) begin
                        state_q <= IDLE;
                        ring_q  <= 1'b0;
                        busy_q  <= 1'b0;
                        bcnt_q  <= '0;
                    end else if (rep_hit) begin
                        state_q <= FAULT;
                        ring_q  <= 1'b0;
                        fault_q <= 1'b1;
                        busy_q  <= 1'b0;
                        bcnt_q  <= '0;
                    end else if (bcnt_q == BIT_LAST) begin
                        state_q <= VALID;
                        shift_q <= shift_nxt;
                        word_q  <= shift_nxt;
                        vld_q   <= 1'b1;
                        busy_q  <= 1'b0;
                        bcnt_q  <= '0;
                    end else begin
                        shift_q <= shift_nxt;
                        bcnt_q  <= bcnt_q + BCW'(1);
                    end
                end
                VALID: begin
                    if (word_ack) begin
                        vld_q <= 1'b0;
                        if (req) begin
                            state_q <= COLLECT;
                            busy_q  <= 1'b1;
                        end else begin
                            state_q <= IDLE;
                            ring_q  <= 1'b0;
                        end
                    end
                end
                FAULT: begin
                    if (clr_fault) begin
                        state_q <= IDLE;
                        fault_q <= 1'b0;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    ring_q  <= 1'b0;
                    vld_q   <= 1'b0;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign ring_en    = ring_q;
    assign word_out   = word_q;
    assign word_valid = vld_q;
    assign fault      = fault_q;
    assign busy       = busy_q;

endmodule

// File: doc/trng_sequencer.md
Name: trng_sequencer

Overview:
Control block for the ring-oscillator random-bit datapath. It enables the inverter rings on request and discards bits during a warm-up interval. It then assembles the post-processed random bit stream into WORD_W-bit words and delivers each word over a valid/ack handshake. A running repetition-count health test stops the rings and raises a sticky fault when the stream sticks at one value.

Parameters:
WARMUP_CYCLES, 64, clk cycles with rings running before bits are accepted (>=1)
WORD_W, 8, bits per delivered word (>=2)
REP_LIMIT, 16, run length of identical consecutive bits that triggers a fault (>=2)

Ports:
clk  in  1  clock
rst_n  in  1  reset, asynchronous, active-high
req  in  1  level request for random words; 1 = keep producing
bit_in  in  1  post-processed random bit, one new bit per clk
ring_en  out  1  inverter ring enable (drives ring start input)
word_out  out  WORD_W  assembled random word; first accepted bit at MSB
word_valid  out  1  word_out holds a fresh word
word_ack  in  1  consumer accepts word when word_valid & word_ack
fault  out  1  sticky health-test failure
clr_fault  in  1  clears fault, returns to IDLE
busy  out  1  state is WARMUP or COLLECT

Behaviour:
- Reset (rst_n=1, async): state IDLE; ring_en=0, word_out=0, word_valid=0, fault=0, busy=0; all counters 0.
- All outputs are registered. Every transition takes effect on the next clk edge.
- IDLE: req=1 -> WARMUP. Load warm-up counter with WARMUP_CYCLES-1 and set ring_en=1.
- WARMUP: ring_en=1, bit_in ignored. Counter decrements each cycle. At 0 -> COLLECT. Clear bit counter and run counter.
- COLLECT: each cycle shift bit_in into the LSB of the shift register. After the WORD_W-th bit -> VALID. word_out gets the completed shift value and word_valid=1. Latency from the first COLLECT cycle to word_valid is WORD_W cycles.
- Repetition test, COLLECT only: run counter resets to 1 when bit_in differs from the previous accepted bit and increments when it matches. Comparison carries across word boundaries within one enabled session. The run counter is cleared on entry to WARMUP. If run reaches REP_LIMIT -> FAULT; this overrides word completion in the same cycle.
- VALID: word_out and word_valid are held stable until ack. ring_en stays 1 and bits are not sampled. On handshake:
  - word_valid=0 next cycle.
  - req=1 -> COLLECT, with no re-warm-up and the previous-bit/run state retained.
  - req=0 -> IDLE, ring_en=0.
- Holding word_ack=1 while word_valid=0 has no effect.
- req dropping in WARMUP or COLLECT -> IDLE next cycle, ring_en=0, partial word discarded. word_out keeps the last delivered value.
- req dropping in VALID does not withdraw the word; the word is still delivered, then the block returns to IDLE.
- FAULT: ring_en=0, word_valid=0, fault=1, req ignored. clr_fault=1 -> IDLE with fault=0. Asserting clr_fault outside FAULT does nothing.
- clr_fault and req both high in FAULT: go to IDLE only. req is evaluated in IDLE on the following cycle, so WARMUP starts 2 cycles after clr_fault.
- Reset mid-operation: immediate return to reset values. Any held word is lost.
- Widths:
  - warm-up counter $clog2(WARMUP_CYCLES+1)
  - bit counter $clog2(WORD_W+1)
  - run counter $clog2(REP_LIMIT+1), saturating at REP_LIMIT.

Decomposition:
- Package trng_pkg: state enum {IDLE, WARMUP, COLLECT, VALID, FAULT} in 3 bits, plus default constants for WARMUP_CYCLES, WORD_W and REP_LIMIT.
- One sub-module, trng_rep_test: previous-bit register, run counter and fault-detect comparator. Inputs are clk, rst_n, clear, sample_en and bit_in; output is hit.
- The sequencer FSM, counters and shift register stay in trng_sequencer.

Test Plan:
- Reset/idle: assert rst_n mid-sim with req=1 -> ring_en, word_valid, fault and busy all 0 within the same cycle, async. Release with req=0 -> ring_en stays 0.
- Basic word (WARMUP_CYCLES=4, WORD_W=8): req=1, ack held 0, bit_in=1,0,1,1,0,0,1,0 after warm-up -> ring_en=1 one cycle after req. word_valid rises 4+8+1 cycles after req, with word_out=8'hB2 held stable.
- Back-to-back: keep req=1, pulse ack for one cycle, then drive bits 0,1,0,1,0,1,0,1 -> no second warm-up. Second word 8'h55 is valid WORD_W cycles after the handshake cycle.
- Abort: drop req after 3 COLLECT bits -> IDLE and ring_en=0 next cycle, no word_valid. Re-raise req -> full warm-up repeats.
- Health fault (REP_LIMIT=5): bit_in constant 1 in COLLECT -> fault=1 and ring_en=0 one cycle after the 5th identical bit, word_valid never set. req ignored. clr_fault with req=1 -> fault=0, IDLE, WARMUP two cycles after clr_fault.
- Run across words (REP_LIMIT=5, WORD_W=4): word ends in 1,1,1 and the next word starts with 1,1 -> fault on the second bit of the next word.
